// File: rtl/datapath_ctrl.sv
// Multi-cycle controller FSM that sequences the register-file/ALU datapath.
// Optional trap on illegal instructions: define DATAPATH_CTRL_TRAP_EN.
module datapath_ctrl #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s,
  input  logic [IW-1:0] in,
  output logic          w,
  output logic          err,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] datapath_in
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_LD_A,
    S_LD_B,
    S_EXEC,
    S_WR_REG
`ifdef DATAPATH_CTRL_TRAP_EN
    , S_ERR
`endif
  } state_t;

  typedef enum logic [2:0] {
    K_MOV_IMM, K_MOV_REG, K_ADD, K_CMP, K_AND, K_MVN, K_ILLEGAL
  } kind_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ir, ir_nxt;
  ctrl_t           ctrl_q;

  function automatic kind_t decode(input logic [IW-1:0] i);
    case ({i[15:13], i[12:11]})
      5'b110_10: decode = K_MOV_IMM;
      5'b110_00: decode = K_MOV_REG;
      5'b101_00: decode = K_ADD;
      5'b101_01: decode = K_CMP;
      5'b101_10: decode = K_AND;
      5'b101_11: decode = K_MVN;
      default:   decode = K_ILLEGAL;
    endcase
  endfunction

  // Control word for a given state/IR; outputs are registered from the
  // next-state values so they line up with the state they describe.
  function automatic ctrl_t moore(input state_t st, input logic [IW-1:0] i);
    kind_t k;
    ctrl_t c;
    k = decode(i);
    c = '0;
    case (st)
      S_WAIT:   c.w = 1'b1;
      S_WR_IMM: begin c.writenum = i[10:8]; c.vsel = 1'b1; c.write = 1'b1; end
      S_LD_A:   begin c.readnum = i[10:8]; c.loada = 1'b1; end
      S_LD_B:   begin c.readnum = i[2:0];  c.loadb = 1'b1; end
      S_EXEC: begin
        c.shift = i[4:3];
        c.asel  = (k == K_MOV_REG) || (k == K_MVN);
        c.aluop = (k == K_MOV_REG) ? 2'b00 : i[12:11];
        c.loads = 1'b1;
        c.loadc = (k != K_CMP);
      end
      S_WR_REG: begin c.writenum = i[7:5]; c.write = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    case (state)
      S_WAIT: if (s) begin
        ir_nxt    = in;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (decode(ir))
          K_MOV_IMM:                state_nxt = S_WR_IMM;
          K_MOV_REG, K_MVN:         state_nxt = S_LD_B;
          K_ADD, K_CMP, K_AND:      state_nxt = S_LD_A;
`ifdef DATAPATH_CTRL_TRAP_EN
          default:                  state_nxt = S_ERR;
`else
          default:                  state_nxt = S_WAIT;
`endif
        endcase
      end
      S_WR_IMM: state_nxt = S_WAIT;
      S_LD_A:   state_nxt = S_LD_B;
      S_LD_B:   state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (decode(ir) == K_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_nxt = S_WAIT;
`ifdef DATAPATH_CTRL_TRAP_EN
      S_ERR:    state_nxt = S_ERR;
`endif
      default:  state_nxt = S_WAIT;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values; IR is reset too so datapath_in is defined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_WAIT;
      ir     <= '0;
      ctrl_q <= moore(S_WAIT, '0);
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      ctrl_q <= moore(state_nxt, ir_nxt);
    end
  end

`ifdef DATAPATH_CTRL_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= (state_nxt == S_ERR);
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign w           = ctrl_q.w;
  assign readnum     = ctrl_q.readnum;
  assign writenum    = ctrl_q.writenum;
  assign write       = ctrl_q.write;
  assign vsel        = ctrl_q.vsel;
  assign loada       = ctrl_q.loada;
  assign loadb       = ctrl_q.loadb;
  assign loadc       = ctrl_q.loadc;
  assign loads       = ctrl_q.loads;
  assign asel        = ctrl_q.asel;
  assign bsel        = ctrl_q.bsel;
  assign shift       = ctrl_q.shift;
  assign ALUop       = ctrl_q.aluop;
  assign datapath_in = {{(IW-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed self-checking bench for datapath_ctrl; honours DATAPATH_CTRL_TRAP_EN.
module tb_datapath_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic [15:0] instr;
  logic        w, err, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  int total = 0;
  int failed = 0;

  datapath_ctrl #(.IW(16)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(instr), .w(w), .err(err),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  // Expected control vector: {w,err,readnum,writenum,write,vsel,la,lb,lc,ls,asel,bsel,shift,aluop}
  function automatic logic [19:0] ctl(input logic w_e, input logic err_e,
      input logic [2:0] rn, input logic [2:0] wn, input logic wr, input logic vs,
      input logic la, input logic lb, input logic lc, input logic ls,
      input logic as, input logic bs, input logic [1:0] sh, input logic [1:0] alu);
    return {w_e, err_e, rn, wn, wr, vs, la, lb, lc, ls, as, bs, sh, alu};
  endfunction

  localparam logic [19:0] IDLE  = 20'h80000;
  localparam logic [19:0] QUIET = 20'h00000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [19:0] exp);
    check(tag, {12'h0, w, err, readnum, writenum, write, vsel, loada, loadb,
                loadc, loads, asel, bsel, shift, ALUop}, {12'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; s = 1'b0; instr = 16'h0;
    #7;
    check_ctl("reset_ctl", IDLE);
    check("reset_dpin", {16'h0, datapath_in}, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Idle with s low: stays in WAIT, IR untouched by a changing in
    instr = 16'hD0FF;
    tick();
    check_ctl("idle_hold", IDLE);
    check("idle_dpin", {16'h0, datapath_in}, 32'h0);

    // MOV R0,#7
    instr = 16'hD007; s = 1'b1;
    tick(); s = 1'b0; instr = 16'h0;
    check_ctl("movi0_decode", QUIET);
    tick();
    check_ctl("movi0_wrimm", ctl(0,0,3'd0,3'd0,1,1,0,0,0,0,0,0,2'b00,2'b00));
    check("movi0_dpin", {16'h0, datapath_in}, 32'h0007);
    tick();
    check_ctl("movi0_done", IDLE);

    // MOV R1,#-16
    instr = 16'hD1F0; s = 1'b1;
    tick(); s = 1'b0; instr = 16'h1234;
    check_ctl("movi1_decode", QUIET);
    tick();
    check_ctl("movi1_wrimm", ctl(0,0,3'd0,3'd1,1,1,0,0,0,0,0,0,2'b00,2'b00));
    check("movi1_dpin", {16'h0, datapath_in}, 32'hFFF0);
    tick();
    check_ctl("movi1_done", IDLE);

    // ADD R2,R1,R0,LSL#1
    instr = 16'hA148; s = 1'b1;
    tick(); s = 1'b0;
    check_ctl("add_decode", QUIET);
    tick();
    check_ctl("add_lda", ctl(0,0,3'd1,3'd0,0,0,1,0,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("add_ldb", ctl(0,0,3'd0,3'd0,0,0,0,1,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("add_exec", ctl(0,0,3'd0,3'd0,0,0,0,0,1,1,0,0,2'b01,2'b00));
    check("add_dpin", {16'h0, datapath_in}, 32'h0048);
    tick();
    check_ctl("add_wrreg", ctl(0,0,3'd0,3'd2,1,0,0,0,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("add_done", IDLE);

    // CMP R0,R0 with s held high throughout, then MOV R3,R2 back-to-back
    instr = 16'hA800; s = 1'b1;
    tick(); instr = 16'hC062;
    check_ctl("cmp_decode", QUIET);
    tick();
    check_ctl("cmp_lda", ctl(0,0,3'd0,3'd0,0,0,1,0,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("cmp_ldb", ctl(0,0,3'd0,3'd0,0,0,0,1,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("cmp_exec", ctl(0,0,3'd0,3'd0,0,0,0,0,0,1,0,0,2'b00,2'b01));
    tick();
    check_ctl("cmp_done", IDLE);
    tick(); s = 1'b0;
    check_ctl("movr_decode", QUIET);
    tick();
    check_ctl("movr_ldb", ctl(0,0,3'd2,3'd0,0,0,0,1,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("movr_exec", ctl(0,0,3'd0,3'd0,0,0,0,0,1,1,1,0,2'b00,2'b00));
    tick();
    check_ctl("movr_wrreg", ctl(0,0,3'd0,3'd3,1,0,0,0,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("movr_done", IDLE);

    // MVN R7,R5,LSR#1 (0xB8F5)
    instr = 16'hB8F5; s = 1'b1;
    tick(); s = 1'b0;
    tick();
    check_ctl("mvn_ldb", ctl(0,0,3'd5,3'd0,0,0,0,1,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("mvn_exec", ctl(0,0,3'd0,3'd0,0,0,0,0,1,1,1,0,2'b10,2'b11));
    tick();
    check_ctl("mvn_wrreg", ctl(0,0,3'd0,3'd7,1,0,0,0,0,0,0,0,2'b00,2'b00));
    tick();
    check_ctl("mvn_done", IDLE);

    // AND R4,R3,R6,ASR (0xB39E): EXEC uses ALUop=10, register A operand
    instr = 16'hB39E; s = 1'b1;
    tick(); s = 1'b0;
    tick(); tick(); tick();
    check_ctl("and_exec", ctl(0,0,3'd0,3'd0,0,0,0,0,1,1,0,0,2'b11,2'b10));
    tick();
    check_ctl("and_wrreg", ctl(0,0,3'd0,3'd4,1,0,0,0,0,0,0,0,2'b00,2'b00));
    tick();

    // Asynchronous reset during EXEC of an ADD
    instr = 16'hA148; s = 1'b1;
    tick(); s = 1'b0;
    tick(); tick(); tick();
    check_ctl("abort_exec", ctl(0,0,3'd0,3'd0,0,0,0,0,1,1,0,0,2'b01,2'b00));
    #2 reset_n = 1'b0;
    #1;
    check_ctl("abort_async", IDLE);
    check("abort_ir", {16'h0, datapath_in}, 32'h0);
    tick();
    check_ctl("abort_nowrite", IDLE);
    #2 reset_n = 1'b1;
    tick();
    check_ctl("abort_idle", IDLE);

    // Illegal instruction 0xE000
    instr = 16'hE000; s = 1'b1;
    tick(); s = 1'b0;
    check_ctl("ill_decode", QUIET);
    tick();
`ifdef DATAPATH_CTRL_TRAP_EN
    check_ctl("ill_trap", ctl(0,1,3'd0,3'd0,0,0,0,0,0,0,0,0,2'b00,2'b00));
    instr = 16'hD007; s = 1'b1;
    tick(); tick(); tick();
    check_ctl("ill_stuck", ctl(0,1,3'd0,3'd0,0,0,0,0,0,0,0,0,2'b00,2'b00));
    s = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_ctl("ill_reset", IDLE);
    #2 reset_n = 1'b1;
`else
    check_ctl("ill_nop", IDLE);
    tick();
    check_ctl("ill_idle", IDLE);
`endif

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end
endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle controller FSM that sequences the existing register-file/ALU datapath.
- Accepts one 16-bit instruction per start handshake, latches it and decodes it. Drives every datapath control input, one stage per cycle, then reports ready.
- Replaces the switch-driven control interface in the board top level. Its outputs connect port-for-port to the datapath's control inputs, and its datapath_in output feeds the datapath's datapath_in port.

Parameters:
- IW, 16, instruction width; fixed encoding below, other values unsupported.

Ports:
- clk  in  1  datapath clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- s  in  1  start; sampled only in WAIT
- in  in  16  instruction; latched into IR when s accepted
- w  out  1  1 = idle/ready for next instruction
- err  out  1  illegal-instruction flag (see Optional Feature)
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write enable
- vsel  out  1  writeback select: 1 = datapath_in, 0 = C register
- loada, loadb, loadc, loads  out  1 each  pipeline/status register loads
- asel, bsel  out  1 each  operand selects; 0 = register operand
- shift  out  2  shifter op
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- datapath_in  out  16  sign-extended IR[7:0]

Behaviour:
- Instruction encoding:
  - IR[15:13] opcode, IR[12:11] op, IR[10:8] Rn, IR[7:5] Rd, IR[4:3] sh, IR[2:0] Rm, IR[7:0] imm8.
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - Any other opcode/op combination is illegal.
- States: WAIT, DECODE, WR_IMM, LD_A, LD_B, EXEC, WR_REG, and ERR (ERR only with the macro).
- Outputs are Moore functions of state and IR only. There is no combinational path from s or in to any output.
- Default for every output in every state: 0, except datapath_in, which always equals {{8{IR[7]}},IR[7:0]}.
- WAIT:
  - w=1.
  - s=1 at a clock edge: IR<=in, go to DECODE. Otherwise stay.
- DECODE (all loads/write 0):
  - MOV imm -> WR_IMM
  - MOV reg, MVN -> LD_B
  - ADD, CMP, AND -> LD_A
  - illegal -> see Optional Feature
- WR_IMM: writenum=Rn, vsel=1, write=1 -> WAIT.
- LD_A: readnum=Rn, loada=1 -> LD_B.
- LD_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC: shift=sh, bsel=0.
  - asel=1 for MOV reg and MVN; asel=0 otherwise.
  - ALUop = op, except MOV reg, which forces ALUop=00.
  - CMP: loads=1, loadc=0 -> WAIT.
  - All others: loadc=1, loads=1 -> WR_REG.
- WR_REG: writenum=Rd, vsel=0, write=1 -> WAIT.
- Latency from the edge that accepts s to w=1 again:
  - MOV imm: 2 cycles
  - MOV reg, MVN: 4 cycles
  - CMP: 4 cycles
  - ADD, AND: 5 cycles
- s is ignored outside WAIT.
- If s is still high when WAIT is re-entered, a new instruction is accepted on the next edge. No gap cycle is required.
- in may change freely after acceptance; IR holds it until the next accept.
- Reset (asynchronous, any time, including mid-instruction):
  - state=WAIT, IR=0, err=0, hence w=1 and all strobes 0.
  - An aborted instruction issues no further write/load pulse.
  - Register contents in the datapath are not touched.
- Release of reset_n is assumed synchronised externally. The first edge after release may accept s.

Optional Feature:
- Macro DATAPATH_CTRL_TRAP_EN.
- Defined:
  - An illegal instruction goes DECODE -> ERR. ERR sets err=1 and w=0, with all strobes 0.
  - ERR is left only by reset_n=0. s is ignored while in ERR.
- Undefined:
  - An illegal instruction is a NOP: DECODE -> WAIT, 1-cycle penalty, no strobes.
  - err is tied to 0 and the ERR state is not synthesised.

Test Plan:
- Reset then 0xD007 (MOV R0,#7) with s pulsed one cycle -> DECODE, then WR_IMM with write=1, writenum=0, vsel=1, datapath_in=0x0007. w=1 exactly 2 edges after accept; datapath R0=7.
- 0xD1F0 (MOV R1,#-16) -> datapath_in=0xFFF0 during WR_IMM, writenum=1.
- With R0=7 and R1=2, 0xA148 (ADD R2,R1,R0,LSL#1):
  - Strobe sequence: loada (readnum=1), then loadb (readnum=0), then loadc+loads (shift=01, ALUop=00), then write (writenum=2).
  - w returns after 5 edges; datapath_out=0x0010.
- 0xA800 (CMP R0,R0) -> loads=1, loadc=0, no write pulse, w after 4 edges, Z_out=1. Then 0xC062 (MOV R3,R2) -> asel=1, ALUop=00, R3=0x0010.
- Assert reset_n=0 during EXEC of an ADD -> w=1 immediately (asynchronously), no WR_REG write occurs, and IR=0 afterwards.
- 0xE000 (illegal):
  - With the macro: err=1 and w=0, stuck until reset; s ignored.
  - Without the macro: no strobes, w=1 after 1 edge, err=0.
